// File: rtl/mux2_stream_arbiter.sv
// Two-source round-robin packet arbiter driving a shared 2:1 data mux into a single
// registered valid/ready output stage; grant is held for a whole packet.
module mux2_stream_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BEATS  = 256,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in0_valid,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_valid,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  mux_sel,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(MAX_BEATS - 1);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e                  state_q, state_d;
  logic                    last_gnt_q, last_gnt_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    err_q, err_d;

  logic                    load, accept, release_pkt, forced;
  logic                    gnt_valid, gnt_last;
  logic [DATA_WIDTH-1:0]   gnt_data;
  logic                    arb_req, arb_gnt;

  always_comb begin
    load        = !out_valid_q || out_ready;
    gnt_valid   = (state_q == StGnt0) ? in0_valid : ((state_q == StGnt1) ? in1_valid : 1'b0);
    gnt_data    = (state_q == StGnt1) ? in1_data : in0_data;
    gnt_last    = (state_q == StGnt1) ? in1_last : in0_last;
    accept      = (state_q != StIdle) && load && gnt_valid;
    // Hitting the beat limit without last ends the grant as if last had been seen.
    forced      = accept && !gnt_last && (cnt_q == CntLast);
    release_pkt = accept && (gnt_last || (cnt_q == CntLast));

    arb_req = in0_valid || in1_valid;
    if (in0_valid && in1_valid) begin
      arb_gnt = !last_gnt_q;
    end else begin
      arb_gnt = in1_valid;
    end

    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    if ((state_q == StIdle) || release_pkt) begin
      cnt_d = '0;
      if (arb_req) begin
        state_d    = arb_gnt ? StGnt1 : StGnt0;
        last_gnt_d = arb_gnt;
      end else begin
        state_d = StIdle;
      end
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end

    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = gnt_data;
        out_last_d = gnt_last;
      end
    end

    err_d = err_q || forced;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in0_ready   = (state_q == StGnt0) && load;
  assign in1_ready   = (state_q == StGnt1) && load;
  assign mux_sel     = (state_q == StGnt1);
  assign busy        = (state_q != StIdle);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (grant owner, beat count, queue of pending output beats).
module tb_mux2_stream_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned MB = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in0_data = '0, in1_data = '0, out_data;
  logic          in0_valid = 1'b0, in0_last = 1'b0, in0_ready;
  logic          in1_valid = 1'b0, in1_last = 1'b0, in1_ready;
  logic          out_valid, out_last, out_ready = 1'b1;
  logic          mux_sel, busy, err_overrun;

  always #5 clk = ~clk;

  mux2_stream_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .mux_sel(mux_sel), .busy(busy), .err_overrun(err_overrun)
  );

  int nchecks = 0, nerr = 0, cyc = 0;
  logic [DW:0] sq0[$], sq1[$];      // {last, data} beats waiting at each source
  bit en0 = 1'b1, en1 = 1'b1;
  // model: grant owner (-1 idle), round-robin pointer, beats in grant, sticky error, output beats
  int mg = -1, mcnt = 0;
  bit mlast = 1'b1, merr = 1'b0, known = 1'b0, acc0, acc1;
  logic [DW:0] mq[$];
  logic [DW-1:0] dlog[$];           // beats the DUT handed downstream
  int dcyc[$];

  task automatic chk1(string name, logic act, logic exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk64(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic arbitrate(bit v0, bit v1);
    mcnt = 0;
    if (v0 && v1) mg = mlast ? 0 : 1;
    else if (v0) mg = 0;
    else if (v1) mg = 1;
    else mg = -1;
    if (mg >= 0) mlast = (mg == 1);
  endtask

  task automatic check_cycle();
    bit ov, ld;
    if (!known) return;
    ov = (mq.size() != 0);
    ld = !ov || out_ready;
    chk1("busy", busy, mg != -1);
    chk1("mux_sel", mux_sel, mg == 1);
    chk1("in0_ready", in0_ready, (mg == 0) && ld);
    chk1("in1_ready", in1_ready, (mg == 1) && ld);
    chk1("err_overrun", err_overrun, merr);
    chk1("out_valid", out_valid, ov);
    if (ov) begin
      chk64("out_data", out_data, mq[0][DW-1:0]);
      chk1("out_last", out_last, mq[0][DW]);
    end
  endtask

  task automatic model_step();
    bit ov, ld, acc;
    logic [DW:0] beat;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      mg = -1; mlast = 1'b1; mcnt = 0; merr = 1'b0; mq.delete(); known = 1'b1;
      return;
    end
    if (!known) return;
    ov = (mq.size() != 0);
    ld = !ov || out_ready;
    if (ov && out_ready) void'(mq.pop_front());
    acc = ld && (((mg == 0) && in0_valid) || ((mg == 1) && in1_valid));
    beat = (mg == 1) ? {in1_last, in1_data} : {in0_last, in0_data};
    if (acc) begin
      mq.push_back(beat);
      if (mg == 0) acc0 = 1'b1;
      else acc1 = 1'b1;
    end
    if (mg == -1) begin
      arbitrate(in0_valid, in1_valid);
    end else if (acc) begin
      mcnt++;
      if (beat[DW] || mcnt == MB) begin
        if (!beat[DW]) merr = 1'b1;
        arbitrate(in0_valid, in1_valid);
      end
    end
  endtask

  task automatic drive();
    in0_valid = en0 && (sq0.size() > 0);
    in0_data  = in0_valid ? sq0[0][DW-1:0] : {$urandom, $urandom};
    in0_last  = in0_valid ? sq0[0][DW] : 1'($urandom);
    in1_valid = en1 && (sq1.size() > 0);
    in1_data  = in1_valid ? sq1[0][DW-1:0] : {$urandom, $urandom};
    in1_last  = in1_valid ? sq1[0][DW] : 1'($urandom);
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    if (out_valid === 1'b1 && out_ready) begin
      dlog.push_back(out_data);
      dcyc.push_back(cyc);
    end
    model_step();
    if (acc0) void'(sq0.pop_front());
    if (acc1) void'(sq1.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(int s, logic [DW-1:0] d, bit l);
    if (s == 0) sq0.push_back({l, d});
    else sq1.push_back({l, d});
  endtask

  task automatic do_reset();
    sq0.delete(); sq1.delete(); dlog.delete(); dcyc.delete();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int guard;
    logic [DW-1:0] e;
    @(posedge clk);
    #1;

    // Reset held two cycles with both sources requesting
    push(0, 64'hA0, 1'b1);
    push(1, 64'hB0, 1'b1);
    step(); step();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in0_ready", in0_ready, 1'b0);
    chk1("rst_in1_ready", in1_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mux_sel", mux_sel, 1'b0);
    chk1("rst_err", err_overrun, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("first_gnt_busy", busy, 1'b1);
    chk1("first_gnt_sel", mux_sel, 1'b0);

    // Single source, 3-beat packet
    do_reset();
    push(0, 64'h1111_1111_1111_1111, 1'b0);
    push(0, 64'h2222_2222_2222_2222, 1'b0);
    push(0, 64'h3333_3333_3333_3333, 1'b1);
    step();
    chk1("s3_gnt_ready", in0_ready, 1'b1);
    step();
    chk64("s3_beat1", out_data, 64'h1111_1111_1111_1111);
    chk1("s3_last1", out_last, 1'b0);
    step();
    chk64("s3_beat2", out_data, 64'h2222_2222_2222_2222);
    chk1("s3_last2", out_last, 1'b0);
    step();
    chk64("s3_beat3", out_data, 64'h3333_3333_3333_3333);
    chk1("s3_last3", out_last, 1'b1);
    step();
    chk1("s3_drained", out_valid, 1'b0);

    // Contention: three 2-beat packets on each source
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        push(0, 64'hA0 + DW'(p * 2 + b), b == 1);
        push(1, 64'hB0 + DW'(p * 2 + b), b == 1);
      end
    end
    guard = 0;
    while (dlog.size() < 12 && guard < 60) begin step(); guard++; end
    chk_int("alt_count", dlog.size(), 12);
    for (int k = 0; k < 12 && k < dlog.size(); k++) begin
      e = (((k / 2) % 2) == 1 ? 64'hB0 : 64'hA0) + DW'((k / 4) * 2 + (k % 2));
      chk64("alt_order", dlog[k], e);
      chk_int("alt_no_bubble", dcyc[k], dcyc[0] + k);
    end

    // Backpressure mid-packet; exactly MAX_BEATS beats with last is not an overrun
    do_reset();
    for (int b = 0; b < 4; b++) push(1, 64'hC0 + DW'(b), b == 3);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("bp_ready_low", in1_ready, 1'b0);
      chk64("bp_data_hold", out_data, 64'hC0);
    end
    out_ready = 1'b1;
    guard = 0;
    while (dlog.size() < 4 && guard < 30) begin step(); guard++; end
    chk_int("bp_count", dlog.size(), 4);
    for (int k = 0; k < 4 && k < dlog.size(); k++) chk64("bp_order", dlog[k], 64'hC0 + DW'(k));
    chk1("bp_no_err", err_overrun, 1'b0);

    // Overrun: six beats without last on source 1
    do_reset();
    for (int b = 0; b < 6; b++) push(1, 64'hD0 + DW'(b), 1'b0);
    step();
    push(0, 64'hE0, 1'b1);
    guard = 0;
    while (sq1.size() > 2 && guard < 30) begin step(); guard++; end
    chk_int("ovr_accepted", sq1.size(), 2);
    chk1("ovr_err", err_overrun, 1'b1);
    chk1("ovr_switch_src0", mux_sel, 1'b0);
    chk1("ovr_busy", busy, 1'b1);
    chk64("ovr_beat4", out_data, 64'hD3);
    chk1("ovr_last_kept", out_last, 1'b0);
    push(1, 64'hD6, 1'b1);
    guard = 0;
    while (dlog.size() < 8 && guard < 30) begin step(); guard++; end
    chk_int("ovr_count", dlog.size(), 8);
    for (int k = 0; k < 8 && k < dlog.size(); k++) begin
      e = (k < 4) ? 64'hD0 + DW'(k) : ((k == 4) ? 64'hE0 : 64'hD0 + DW'(k - 1));
      chk64("ovr_order", dlog[k], e);
    end
    chk1("ovr_sticky", err_overrun, 1'b1);

    // Reset after beat 2 of a 5-beat packet
    do_reset();
    for (int b = 0; b < 5; b++) push(1, 64'hF0 + DW'(b), b == 4);
    guard = 0;
    while (sq1.size() > 3 && guard < 30) begin step(); guard++; end
    chk_int("mid_accepted", sq1.size(), 3);
    rst_n = 1'b0;
    sq1.delete();
    push(0, 64'h60, 1'b1);
    push(1, 64'h70, 1'b1);
    step();
    chk1("mid_out_valid", out_valid, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    rst_n = 1'b1;
    dlog.delete();
    step();
    chk1("mid_src0_wins", mux_sel, 1'b0);
    chk1("mid_busy_gnt", busy, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk_int("mid_count", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk64("mid_first", dlog[0], 64'h60);
      chk64("mid_second", dlog[1], 64'h70);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (((s == 0) ? sq0.size() : sq1.size()) < 8 && ($urandom % 3) == 0) begin
          int len;
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push(s, {$urandom, $urandom}, b == len - 1);
        end
      end
      en0       = ($urandom % 4) != 0;
      en1       = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      rst_n     = ($urandom % 500) != 0;
      step();
    end
    en0 = 1'b0;
    en1 = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit datapath (the 2:1 select mux, S input) between two packet sources.
- Holds its grant for a whole packet, from first beat through the beat flagged last.
- Drives the mux select and registers the selected beat into a single output stage with a valid/ready handshake.
- Sits between the two packet producers and the shared downstream consumer in the CPU/packet path.

Parameters:
- DATA_WIDTH, 64, width of each source and of the output data.
- MAX_BEATS, 256, maximum accepted beats per grant before a forced release.
- CNT_WIDTH, 9, beat counter width; must satisfy 2^CNT_WIDTH > MAX_BEATS.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- in0_data  in  DATA_WIDTH  source 0 beat.
- in0_valid  in  1  source 0 beat valid.
- in0_last  in  1  source 0 final beat of packet.
- in0_ready  out  1  source 0 beat accepted this cycle when in0_valid=1.
- in1_data, in1_valid, in1_last, in1_ready: same as source 0, for source 1.
- out_data  out  DATA_WIDTH  registered output beat.
- out_valid  out  1  output beat valid.
- out_last  out  1  output final beat.
- out_ready  in  1  downstream accepts when out_valid=1.
- mux_sel  out  1  select to the shared mux: 0=source 0, 1=source 1.
- busy  out  1  a grant is active.
- err_overrun  out  1  sticky: a packet exceeded MAX_BEATS.

Behaviour:
- States: IDLE, GNT0, GNT1. busy=1 in GNT0/GNT1. mux_sel=1 only in GNT1; 0 otherwise.
- Reset (rst_n=0 at a clock edge), regardless of state or transfer in flight:
  - state=IDLE; out_valid=0, out_last=0, out_data=0; err_overrun=0; beat count=0.
  - Round-robin pointer last_gnt=1, so source 0 wins the first contention.
  - A partial packet is dropped; the bench must not expect its remainder.
- Output stage is one register. load = !out_valid || out_ready.
- in0_ready = (state==GNT0) && load; in1_ready = (state==GNT1) && load. Both are 0 in IDLE.
- Accept: granted source has valid=1 and ready=1.
  - Next cycle: out_data and out_last hold that beat, out_valid=1.
  - Latency is exactly 1 cycle.
- out_valid=1 with out_ready=0: out_data, out_last and out_valid hold unchanged.
- No accept while load=1: out_valid clears to 0 if it was being consumed.
- Arbitration, evaluated in IDLE and at the release edge:
  - Only one valid: grant that source.
  - Both valid: grant the source != last_gnt.
  - Neither valid: go to IDLE.
  - last_gnt updates to the newly granted source.
- IDLE with a valid request: grant next cycle; first beat can be accepted in the GNTx cycle.
- Release:
  - On the cycle an accepted beat has last=1, arbitrate and move directly to the next GNTx or IDLE.
  - Back-to-back packets from different sources therefore have no bubble.
  - Re-grant of the same source is allowed only when the other source is not valid.
- Beat counter:
  - Clears on grant; increments per accepted beat.
  - Accepted beat with last=0 while count==MAX_BEATS-1: force release as if last.
  - Forced release sets err_overrun=1 (sticky until reset); out_last of that beat stays as supplied (0).
- Grant held with the granted source's valid=0: stay in GNTx and wait. No timeout.
- Non-granted source's valid and data are ignored; its ready stays 0.
- Single-beat packet (valid and last together): legal; grant lasts one accepted beat.

Test Plan:
- Reset then idle:
  - rst_n=0 for 2 cycles with both valid=1.
  - Expect out_valid=0, both ready=0, busy=0, mux_sel=0, err_overrun=0.
  - rst_n=1: GNT0 the next cycle.
- Single source, 3-beat packet:
  - in0 sends 0x1111…, 0x2222…, 0x3333… (last on beat 3), out_ready=1.
  - Expect out_data shows the same sequence, each 1 cycle after accept; out_last only on 0x3333…; then IDLE.
- Contention alternation:
  - Both sources continuously send 2-beat packets.
  - Expect order src0, src1, src0, src1; mux_sel toggles; zero idle cycles between packets.
- Backpressure:
  - out_ready=0 for 4 cycles mid-packet.
  - Expect out_data stable, granted ready=0 after the register fills, no beat lost or duplicated.
  - Resume yields the remaining beats in order.
- Overrun:
  - Set MAX_BEATS=4; source 1 sends 6 beats with no last.
  - Expect release after the 4th accepted beat, err_overrun=1, source 0 granted next if valid.
- Reset mid-packet:
  - Assert rst_n=0 after beat 2 of a 5-beat packet.
  - Expect state IDLE, out_valid=0, and src0 wins the next contention.
